// File: rtl/nd4_deserializer.sv
// nd4_deserializer: serial-to-parallel receiver.
// The receiver collects WIDTH bits from D, taking a bit only on cycles with EN=1.
// SYNC marks the start of each frame. A finished word is handed to a
// one-entry valid/ready output buffer.
//
// Ports:
//   CK    clock, rising edge
//   RN    asynchronous active-low reset
//   D     serial data, sampled when EN=1
//   EN    bit strobe
//   SYNC  frame start (qualified by EN)
//   CLR   synchronous clear of the OVF/RSY sticky flags
//   Q     assembled word, held stable while QV=1
//   QV    output word valid
//   QR    consumer ready
//   OVF   sticky: a completed word was dropped because the buffer was full
//   RSY   sticky: a partial word was discarded by a mid-word SYNC
module nd4_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             D,
    input  logic             EN,
    input  logic             SYNC,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    output logic             OVF,
    output logic             RSY
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count, count_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic [WIDTH-1:0] q_nx;
    logic             qv_nx, ovf_nx, rsy_nx;

    logic             capture, resync, complete;
    logic [CW-1:0]    pos, idx;
    logic [WIDTH-1:0] word;

    // Next-state, capture and output-buffer logic
    always_comb begin
        state_nx = state;
        count_nx = count;
        sr_nx    = sr;
        q_nx     = Q;
        qv_nx    = QV;
        ovf_nx   = OVF;
        rsy_nx   = RSY;
        capture  = 1'b0;
        resync   = 1'b0;
        complete = 1'b0;
        pos      = '0;
        idx      = '0;
        word     = sr;

        if (EN) begin
            case (state)
                IDLE:    capture = SYNC;
                SHIFT: begin
                    capture = 1'b1;
                    // A SYNC on the final bit position counts as data.
                    resync  = SYNC && (count != LAST);
                end
                default: capture = 1'b0;
            endcase
        end

        pos  = ((state == IDLE) || resync) ? '0 : count;
        idx  = MSB_FIRST ? (LAST - pos) : pos;
        // Bit 0 starts a fresh word so stale bits never leak in.
        word = (pos == '0) ? '0 : sr;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) == idx) begin
                word[i] = D;
            end
        end
        complete = capture && (pos == LAST);

        if (capture) begin
            sr_nx = word;
            if (complete) begin
                count_nx = '0;
                state_nx = IDLE;
            end else begin
                count_nx = pos + CW'(1);
                state_nx = SHIFT;
            end
        end

        // Output buffer: drain first, then a completing word may refill it.
        if (QV && QR) begin
            qv_nx = 1'b0;
        end

        // Clear first so a same-cycle set event wins.
        if (CLR) begin
            ovf_nx = 1'b0;
            rsy_nx = 1'b0;
        end

        if (complete) begin
            if (!QV || QR) begin
                q_nx  = word;
                qv_nx = 1'b1;
            end else begin
                ovf_nx = 1'b1;
            end
        end

        if (resync) begin
            rsy_nx = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            count <= '0;
            sr    <= '0;
            Q     <= '0;
            QV    <= 1'b0;
            OVF   <= 1'b0;
            RSY   <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            sr    <= sr_nx;
            Q     <= q_nx;
            QV    <= qv_nx;
            OVF   <= ovf_nx;
            RSY   <= rsy_nx;
        end
    end

endmodule

// File: tb/tb_nd4_deserializer.sv
// Scoreboard bench for nd4_deserializer, WIDTH=4. One instance uses LSB-first
// bit order and a second uses MSB-first bit order. Both share the same stimulus.
module tb_nd4_deserializer;

    logic       ck, rn, d, en, sync, clr, qr;
    logic [3:0] q0, q1;
    logic       qv0, qv1, ovf0, ovf1, rsy0, rsy1;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb0[$];
    logic [3:0] sb1[$];

    nd4_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u0 (
        .CK(ck), .RN(rn), .D(d), .EN(en), .SYNC(sync), .CLR(clr),
        .Q(q0), .QV(qv0), .QR(qr), .OVF(ovf0), .RSY(rsy0)
    );

    nd4_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u1 (
        .CK(ck), .RN(rn), .D(d), .EN(en), .SYNC(sync), .CLR(clr),
        .Q(q1), .QV(qv1), .QR(qr), .OVF(ovf1), .RSY(rsy1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer (QV=1 and QR=1) must match the next expected word.
    always @(negedge ck) begin
        if (rn === 1'b1 && qv0 === 1'b1 && qr === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0_extra_word: got %0h, expected no transfer", q0);
            end else begin
                chk("u0_word", 32'(q0), 32'(sb0.pop_front()));
            end
        end
        if (rn === 1'b1 && qv1 === 1'b1 && qr === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1_extra_word: got %0h, expected no transfer", q1);
            end else begin
                chk("u1_word", 32'(q1), 32'(sb1.pop_front()));
            end
        end
    end

    task automatic cyc(input logic d_i, input logic en_i, input logic sync_i);
        d = d_i; en = en_i; sync = sync_i;
        @(posedge ck);
        #1;
        en = 1'b0; sync = 1'b0; d = 1'bx;
    endtask

    // An EN=0 cycle with SYNC=1 and D=X. It must have no effect.
    task automatic idle_cyc();
        cyc(1'bx, 1'b0, 1'b1);
    endtask

    // Sends bits[0] first, with SYNC on the first bit. If push is set, the
    // expected words for both instances go onto the scoreboard.
    task automatic frame(input logic [3:0] bits, input logic [3:0] e0,
                         input logic [3:0] e1, input bit push);
        if (push) begin
            sb0.push_back(e0);
            sb1.push_back(e1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(bits[k], 1'b1, (k == 0));
        end
    endtask

    initial begin
        rn = 1'b0; d = 1'b0; en = 1'b0; sync = 1'b0; clr = 1'b0; qr = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        chk("reset_q", 32'(q0), 32'h0);
        chk("reset_qv", 32'(qv0), 32'h0);
        chk("reset_ovf", 32'(ovf0), 32'h0);
        chk("reset_rsy", 32'(rsy0), 32'h0);
        rn = 1'b1;
        idle_cyc();

        // Hold a word with QR=0. Then reset mid-word.
        frame(4'b1101, 4'hD, 4'hB, 1'b0);
        chk("hold_qv", 32'(qv0), 32'h1);
        chk("hold_q_lsb", 32'(q0), 32'hD);
        chk("hold_q_msb", 32'(q1), 32'hB);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        #2 rn = 1'b0;
        #1;
        chk("midrst_q", 32'(q0), 32'h0);
        chk("midrst_qv", 32'(qv0), 32'h0);
        chk("midrst_ovf", 32'(ovf0), 32'h0);
        chk("midrst_rsy", 32'(rsy0), 32'h0);
        chk("midrst_q_msb", 32'(q1), 32'h0);
        @(posedge ck);
        #1 rn = 1'b1;

        // A clean frame after reset, at continuous EN with QR=1. Also checks latency.
        qr = 1'b1;
        sb0.push_back(4'hD);
        sb1.push_back(4'hB);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("lat_qv_before", 32'(qv0), 32'h0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("lat_qv_after", 32'(qv0), 32'h1);
        idle_cyc();
        chk("lat_qv_onecycle", 32'(qv0), 32'h0);

        // EN toggles every other cycle. The EN=0 cycles carry SYNC=1 and D=X.
        sb0.push_back(4'h6);
        sb1.push_back(4'h6);
        cyc(1'b0, 1'b1, 1'b1); idle_cyc();
        cyc(1'b1, 1'b1, 1'b0); idle_cyc();
        cyc(1'b1, 1'b1, 1'b0); idle_cyc();
        chk("toggle_qv_early", 32'(qv0), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("toggle_rsy", 32'(rsy0), 32'h0);
        idle_cyc();

        // QR=0: the second word of two back-to-back frames is dropped.
        qr = 1'b0;
        frame(4'hA, 4'hA, 4'h5, 1'b1);
        frame(4'h5, 4'h5, 4'hA, 1'b0);
        chk("ovf_q", 32'(q0), 32'hA);
        chk("ovf_q_msb", 32'(q1), 32'h5);
        chk("ovf_qv", 32'(qv0), 32'h1);
        chk("ovf_set", 32'(ovf0), 32'h1);
        chk("ovf_set_msb", 32'(ovf1), 32'h1);
        clr = 1'b1;
        idle_cyc();
        clr = 1'b0;
        chk("ovf_clr", 32'(ovf0), 32'h0);
        // A CLR in the same cycle as a drop: the set wins.
        clr = 1'b1;
        frame(4'h9, 4'h9, 4'h9, 1'b0);
        chk("ovf_set_wins", 32'(ovf0), 32'h1);
        chk("ovf_q_stable", 32'(q0), 32'hA);
        idle_cyc();
        clr = 1'b0;
        chk("ovf_clr2", 32'(ovf0), 32'h0);
        qr = 1'b1;
        idle_cyc();
        chk("drain_qv", 32'(qv0), 32'h0);
        chk("drain_q_hold", 32'(q0), 32'hA);

        // Resync after 2 bits.
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        frame(4'hF, 4'hF, 4'hF, 1'b1);
        chk("rsy_set", 32'(rsy0), 32'h1);
        chk("rsy_set_msb", 32'(rsy1), 32'h1);
        idle_cyc();
        clr = 1'b1;
        idle_cyc();
        clr = 1'b0;
        chk("rsy_clr", 32'(rsy0), 32'h0);
        // A SYNC on the 4th bit counts as data.
        sb0.push_back(4'hC);
        sb1.push_back(4'h3);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("sync_last_rsy", 32'(rsy0), 32'h0);
        chk("sync_last_qv", 32'(qv0), 32'h1);
        idle_cyc();

        // A transfer and a completion in the same cycle.
        qr = 1'b0;
        frame(4'h3, 4'h3, 4'hC, 1'b1);
        sb0.push_back(4'hC);
        sb1.push_back(4'h3);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        qr = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        chk("simul_q", 32'(q0), 32'hC);
        chk("simul_q_msb", 32'(q1), 32'h3);
        chk("simul_qv", 32'(qv0), 32'h1);
        chk("simul_ovf", 32'(ovf0), 32'h0);
        idle_cyc();
        chk("simul_qv_drain", 32'(qv0), 32'h0);

        repeat (3) idle_cyc();
        chk("sb0_empty", 32'(sb0.size()), 32'h0);
        chk("sb1_empty", 32'(sb1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nd4_deserializer.md
Name: nd4_deserializer

Overview:
- Serial-to-parallel receive companion for the 4-input gate primitives in the ECP cell library.
- Reduces the wide parallel side back out of a single serial line: assembles a WIDTH-bit word from bits on D, qualified by EN and framed by SYNC.
- Presents each word on a one-entry valid/ready output buffer.
- Used in simulation models wherever a serial cell-chain output must be turned back into parallel data.

Parameters:
- WIDTH, 4, number of bits per word; legal range 2..16.
- MSB_FIRST, 0, 0 = first received bit lands in Q[0]; 1 = first received bit lands in Q[WIDTH-1].

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RN  input  1  asynchronous active-low reset.
- D  input  1  serial data bit, sampled when EN=1.
- EN  input  1  bit strobe; D, SYNC and the bit counter are evaluated only in cycles with EN=1.
- SYNC  input  1  frame start, qualified by EN; marks the current D as bit 0 of a new word.
- CLR  input  1  synchronous clear of the OVF and RSY sticky flags.
- Q  output  WIDTH  assembled word; stable while QV=1.
- QV  output  1  output word valid.
- QR  input  1  consumer ready; a word transfers on a cycle where QV=1 and QR=1.
- OVF  output  1  sticky: a completed word was dropped because the output buffer was full.
- RSY  output  1  sticky: SYNC arrived mid-word and the partial word was discarded.

Behaviour:
- Reset (RN=0, asynchronous):
  - state = IDLE, bit counter = 0, shift register = 0.
  - Q = 0, QV = 0, OVF = 0, RSY = 0.
  - Applies immediately, including mid-word; any partial word is lost.
- States:
  - IDLE: EN=1 and SYNC=1 captures D as bit 0, sets count = 1 and moves to SHIFT. EN=1 with SYNC=0 is ignored.
  - SHIFT: each EN=1 cycle captures D into the next position and increments count.
  - Word completion: the capture that makes count = WIDTH completes the word, resets count to 0 and returns to IDLE.
  - Cycles with EN=0 hold all state.
- Resync:
  - In SHIFT, EN=1 and SYNC=1 discards the partial word, sets RSY = 1, captures D as the new bit 0, sets count = 1 and stays in SHIFT.
  - Exception: if this is the capture that would complete the word (count = WIDTH-1), the SYNC bit is treated as the final data bit; there is no resync and RSY is not set.
- Bit placement:
  - MSB_FIRST=0: bit k goes to word[k].
  - MSB_FIRST=1: bit k goes to word[WIDTH-1-k].
- Output buffer and latency:
  - On completion, if QV=0, or if QV=1 and QR=1 in the same cycle, the word loads into Q and QV=1 on the next edge.
  - Latency is one cycle from the final-bit capture edge: QV rises at that edge.
  - If QV=1 and QR=0 at completion, the new word is dropped, Q is unchanged and OVF is set to 1.
  - QV=1 with QR=1 and no completion: QV clears at the next edge. Q holds its last value; it is not cleared.
  - While QV=1, Q must not change until the transfer occurs.
- Flags:
  - OVF and RSY stay set until CLR=1 or reset.
  - CLR=1 in the same cycle as a new set event: the set wins, and the flag reads 1.
- Back-to-back words: SYNC is legal on the EN cycle immediately after completion (state IDLE). There is no dead cycle at full EN rate.
- QR is ignored while QV=0.
- X/Z on D in a non-EN cycle has no effect.

Test Plan:
- Reset mid-word, WIDTH=4: assert RN=0 after 2 bits -> QV=0, Q=0, OVF=0, RSY=0 immediately. A following full frame is received cleanly.
- WIDTH=4, MSB_FIRST=0, continuous EN, QR=1, bits 1,0,1,1 with SYNC on the first -> Q=4'b1101, QV=1 for one cycle, one cycle after the 4th bit. Repeat with MSB_FIRST=1 -> Q=4'b1011.
- EN toggling every other cycle, bits 0,1,1,0 -> Q=4'b0110. Count and state hold during EN=0 cycles.
- QR=0, send two frames back-to-back (0xA then 0x5) -> Q stays 0xA, QV=1, OVF=1. Then CLR=1 -> OVF=0. Then QR=1 -> QV=0 next cycle.
- SYNC after 2 bits, then bits 1,1,1,1 with SYNC on the first of them -> RSY=1, Q=4'hF. SYNC on the 4th bit of a frame -> treated as data, RSY unchanged.
- Simultaneous transfer and completion: QV=1 holding 0x3, QR=1 on the same edge that 0xC completes -> Q=0xC, QV stays 1, OVF=0.
